// File: rtl/muladd_seq_pkg.sv
// Shared types and defaults for the muladd_seq dot-product sequencer.
package muladd_seq_pkg;

    localparam int DEF_DEPTH = 16;
    localparam int DEF_AW    = 4;
    localparam int DEF_DW    = 16;
    localparam int DEF_RW    = 32;

    // Result reported when the watchdog gives up on the core.
    localparam logic [31:0] TIMEOUT_RESULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/muladd_opbuf.sv
// Operand buffer: DEPTH x DW array, one write port, one registered
// ce-qualified read port whose output holds between enabled reads.
module muladd_opbuf
    import muladd_seq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= '0;
        else if (re) q <= mem[raddr];
    end

endmodule

// File: rtl/muladd_seq.sv
// Sequencer for an ap_ctrl_hs dot-product core: operand buffers, start
// handshake and valid/ready result capture. Watchdog: MULADD_SEQ_WATCHDOG_EN.
module muladd_seq
    import muladd_seq_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW,
    parameter int RW          = DEF_RW,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic          ap_clk,
    input  logic          ap_rst,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_err,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [RW-1:0] res_data,
    output logic          busy,
    output logic          core_start,
    input  logic          core_done,
    input  logic          core_idle,
    input  logic          core_ready,
    input  logic [RW-1:0] core_ret,
    input  logic [AW-1:0] a_address0,
    input  logic          a_ce0,
    output logic [DW-1:0] a_q0,
    input  logic [AW-1:0] b_address0,
    input  logic          b_ce0,
    output logic [DW-1:0] b_q0
`ifdef MULADD_SEQ_WATCHDOG_EN
    ,
    output logic          timeout
`endif
);

    state_t state, state_nx;
    logic   accept, wr_ok, run_done, wd_hit, active;
    logic   unused;

    assign active   = (state == START) || (state == RUN);
    assign accept   = cmd_valid && cmd_ready;
    assign wr_ok    = wr_en && !active;
    // A combinational core may finish in the same cycle it acknowledges start.
    assign run_done = core_done && (((state == START) && core_ready) || (state == RUN));
    assign unused   = core_idle ^ (TIMEOUT_CYC == 0);

`ifdef MULADD_SEQ_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] wd_cnt;

    assign wd_hit = active && !run_done && (wd_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (accept)      wd_cnt <= '0;
            else if (active) wd_cnt <= wd_cnt + CW'(1);
            if (accept)      timeout <= 1'b0;
            else if (wd_hit) timeout <= 1'b1;
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = START;
            START:   if (run_done || wd_hit) state_nx = HOLD;
                     else if (core_ready)    state_nx = RUN;
            RUN:     if (run_done || wd_hit) state_nx = HOLD;
            HOLD:    if (res_valid && res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        core_start = (state == START);
        busy       = (state != IDLE);
        cmd_ready  = (state == IDLE) && !res_valid;
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            wr_err    <= 1'b0;
        end else begin
            wr_err <= wr_en && active;
            if (run_done) begin
                res_data  <= core_ret;
                res_valid <= 1'b1;
            end else if (wd_hit) begin
                res_data  <= RW'(TIMEOUT_RESULT);
                res_valid <= 1'b1;
            end else if ((state == HOLD) && res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    muladd_opbuf #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_buf_a (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .we    (wr_ok && !wr_sel),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (a_ce0),
        .raddr (a_address0),
        .q     (a_q0)
    );

    muladd_opbuf #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_buf_b (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .we    (wr_ok && wr_sel),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (b_ce0),
        .raddr (b_address0),
        .q     (b_q0)
    );

endmodule

// File: doc/muladd_seq.md
Name: muladd_seq

Overview:
Sequencer for the HLS dot-product core (ap_ctrl_hs, two ap_memory operand ports, 32-bit ap_return).
- Owns both 16-entry operand buffers and accepts host writes.
- On a host command, pulses the core start handshake and serves the core's a/b reads with BRAM-style one-cycle latency.
- Captures ap_return into a valid/ready result register.
- Sits between the host/register side and the core instance.

Parameters:
- DEPTH, 16, entries per operand buffer (power of 2).
- AW, 4, address width, equals log2(DEPTH).
- DW, 16, operand width.
- RW, 32, result width.
- TIMEOUT_CYC, 4096, watchdog limit in cycles (used only with the optional feature).

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst  in  1  reset, asynchronous and active-high.
- wr_en  in  1  host operand write strobe.
- wr_sel  in  1  0 = a buffer, 1 = b buffer.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- wr_err  out  1  one-cycle pulse when a write is dropped because the block is busy.
- cmd_valid  in  1  host requests one run.
- cmd_ready  out  1  high only in IDLE.
- res_valid  out  1  result held.
- res_ready  in  1  host consumes the result.
- res_data  out  RW  captured ap_return.
- busy  out  1  high whenever state != IDLE.
- core_start  out  1  to core ap_start.
- core_done  in  1  from core ap_done.
- core_idle  in  1  from core ap_idle (status only).
- core_ready  in  1  from core ap_ready.
- core_ret  in  RW  from core ap_return.
- a_address0  in  AW  core read address, a.
- a_ce0  in  1  core read enable, a.
- a_q0  out  DW  read data, a.
- b_address0  in  AW  core read address, b.
- b_ce0  in  1  core read enable, b.
- b_q0  out  DW  read data, b.

Behaviour:
- Reset values: all outputs 0, state IDLE, buffer contents undefined. The exception is cmd_ready, which is 1 from the first cycle after reset deasserts.
- Reset mid-operation: state returns to IDLE immediately and core_start drops. A result not yet captured is lost.
- Writes:
  - Accepted only in IDLE or HOLD.
  - In START or RUN, the write is ignored and wr_err pulses high the next cycle.
- Reads:
  - If a_ce0 is high at edge N, a_q0 holds buf_a[a_address0] from N+1 until the next ce-qualified edge. b is identical and independent.
  - Without ce0, q0 holds its previous value.
- FSM:
  - IDLE: cmd_valid && cmd_ready, with res_valid low, goes to START. If res_valid is high, cmd_ready stays 0, so no new run starts until the result is drained.
  - START: core_start = 1 and is held until the cycle core_ready = 1, then goes to RUN and core_start = 0 on the next cycle.
  - RUN: on core_done, res_data <= core_ret and res_valid <= 1, go to HOLD.
  - Same-cycle ready and done: a combinational core can assert core_ready and core_done in the same cycle while in START. In that case go directly to HOLD and capture core_ret.
  - HOLD: when res_valid && res_ready, clear res_valid and go to IDLE.
- Run latency: cmd accept to core_start is 1 cycle; done to res_valid is 1 cycle.
- Result width: res_data is stored as-is with no sign extension (RW == core width).
- core_idle is not used for control.

Optional Feature:
- Macro MULADD_SEQ_WATCHDOG_EN.
- Defined:
  - A counter runs in START/RUN and clears on entry to START.
  - If it reaches TIMEOUT_CYC, capture res_data = 32'hDEAD_BEEF, set res_valid and a sticky output port timeout (1 bit, cleared by reset or by the next accepted cmd), and go to HOLD.
- Undefined: no counter, no timeout port, and the block waits indefinitely in START/RUN.

Decomposition:
- Package muladd_seq_pkg holds:
  - state enum {IDLE, START, RUN, HOLD}, 2 bits;
  - localparams AW/DW/RW defaults;
  - the TIMEOUT_RESULT constant 32'hDEADBEEF.
- Sub-module muladd_opbuf: DEPTH x DW, one write port, one registered ce-qualified read port. Instantiated twice (a, b).

Test Plan:
- Load a[i]=i, b[i]=i+1 for i=0..15, pulse cmd with res_ready=0.
  - Expect res_valid=1, res_data=0x00000550 held stable, and cmd_ready=0 until res_ready.
  - Then IDLE with cmd_ready=1.
- Core model delays core_ready by 3 cycles: core_start stays high exactly until the core_ready cycle, then drops. Exactly one run occurs.
- wr_en to address 5 during RUN:
  - wr_err pulses 1 cycle and the buffer is unchanged.
  - A rerun with same data gives 0x550; rerun after a legal write a[5]=0 gives 0x550-30=0x532.
- Assert ap_rst in RUN:
  - core_start=0, res_valid=0, busy=0 immediately.
  - A subsequent cmd runs normally and gives 0x550.
- Combinational core asserting core_ready and core_done together in START: result is captured and the state is HOLD within 1 cycle.
- With MULADD_SEQ_WATCHDOG_EN and TIMEOUT_CYC=64, core never asserts done: after 64 cycles, res_data=0xDEADBEEF, timeout=1, and the next cmd clears timeout.
